// File: rtl/mio_arb_pkg.sv
// rtl/mio_arb_pkg.sv - shared owner encodings and defaults for the MIO bus arbiter
//
// Contents:
//   owner_t          one-hot owner encoding, also driven directly onto grant
//   TIMEOUT_CYC_DEF  default watchdog limit for a locked DMA burst
//   cnt_width()      counter width able to hold 0..limit
package mio_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_CPU  = 2'b01,
        GNT_DMA  = 2'b10
    } owner_t;

    localparam int TIMEOUT_CYC_DEF = 64;

    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mio_arb_wdog.sv
// rtl/mio_arb_wdog.sv - locked-DMA watchdog forcing the bus back to the CPU
//
// Parameters:
//   TIMEOUT_CYC    consecutive locked DMA cycles allowed before a forced release
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   locked         DMA owns the bus this cycle with dma_req & dma_lock
//   owner_change   owner register will take a different value at this edge
//   cpu_req        CPU is waiting for the bus
//   force_release  combinational: this is the last locked cycle DMA is granted
//   timeout_flag   registered one-cycle pulse in the first cycle after release
module mio_arb_wdog
    import mio_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic locked,
    input  logic owner_change,
    input  logic cpu_req,
    output logic force_release,
    output logic timeout_flag
);

    localparam int            CW       = cnt_width(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // cnt holds the number of locked DMA cycles already completed, so the
    // current cycle is number cnt+1; release fires when that reaches the limit.
    logic [CW-1:0] cnt;

    assign force_release = locked && cpu_req && (cnt >= CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt          <= '0;
            timeout_flag <= 1'b0;
        end else begin
            timeout_flag <= force_release;
            // With no CPU waiting the lock is honoured and the count parks at the limit.
            if (locked && !owner_change) begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_ONE;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mio_bus_arbiter.sv
// rtl/mio_bus_arbiter.sv - two-master (CPU/DMA) arbiter for the MIO address decoder
//
// Build option: define MIO_ARB_TIMEOUT_EN to include the locked-DMA watchdog;
// without it the lock is honoured indefinitely and timeout_flag is tied low.
//
// Ports:
//   clk, rst                          clock, synchronous active-low reset
//   cpu_req/addr/wdata/we             CPU bus cycle request
//   cpu_rdata, cpu_ack                CPU read data and per-cycle acknowledge
//   dma_req/lock/addr/wdata/we        DMA bus cycle request, lock holds a burst
//   dma_rdata, dma_ack                DMA read data and per-cycle acknowledge
//   bus_addr, bus_wdata, bus_mem_w    muxed cycle towards the decoder
//   bus_rdata                         decoder read-back
//   grant                             registered one-hot owner (01 CPU, 10 DMA)
//   timeout_flag                      pulse after a forced DMA release
module mio_bus_arbiter
    import mio_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic        dma_lock,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic        dma_we,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_mem_w,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  grant,
    output logic        timeout_flag
);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("mio_bus_arbiter: TIMEOUT_CYC must be at least 1");
    end

    owner_t owner;
    owner_t last_gnt;
    owner_t next_owner;
    logic   dma_keep;
    logic   force_release;
    logic   cpu_sel;
    logic   dma_sel;

    // A master is serviced only in cycles where it owns the bus and still
    // requests; this single term drives ack, data return and the write strobe.
    assign cpu_sel = (owner == GNT_CPU) && cpu_req;
    assign dma_sel = (owner == GNT_DMA) && dma_req;

    assign dma_keep = (owner == GNT_DMA) && dma_req && dma_lock;

    always_comb begin
        next_owner = GNT_NONE;
        if (dma_keep && !force_release) begin
            next_owner = GNT_DMA;
        end else if (force_release) begin
            next_owner = GNT_CPU;
        end else if (cpu_req && dma_req) begin
            next_owner = (last_gnt == GNT_CPU) ? GNT_DMA : GNT_CPU;
        end else if (cpu_req) begin
            next_owner = GNT_CPU;
        end else if (dma_req) begin
            next_owner = GNT_DMA;
        end
    end

    // last_gnt starts at DMA so the CPU wins the first contention after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner    <= GNT_NONE;
            last_gnt <= GNT_DMA;
        end else begin
            owner <= next_owner;
            if (next_owner != GNT_NONE) begin
                last_gnt <= next_owner;
            end
        end
    end

    assign grant = owner;

    assign cpu_ack   = cpu_sel;
    assign dma_ack   = dma_sel;
    assign cpu_rdata = cpu_sel ? bus_rdata : 32'd0;
    assign dma_rdata = dma_sel ? bus_rdata : 32'd0;

    assign bus_addr  = cpu_sel ? cpu_addr  : (dma_sel ? dma_addr  : 32'd0);
    assign bus_wdata = cpu_sel ? cpu_wdata : (dma_sel ? dma_wdata : 32'd0);
    assign bus_mem_w = (cpu_sel && cpu_we) || (dma_sel && dma_we);

`ifdef MIO_ARB_TIMEOUT_EN
    logic owner_change;
    assign owner_change = (next_owner != owner);

    mio_arb_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk          (clk),
        .rst          (rst),
        .locked       (dma_keep),
        .owner_change (owner_change),
        .cpu_req      (cpu_req),
        .force_release(force_release),
        .timeout_flag (timeout_flag)
    );
`else
    assign force_release = 1'b0;
    assign timeout_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// tb/tb_mio_bus_arbiter.sv - self-checking bench: vector table, corner sequences, random vs model
module tb_mio_bus_arbiter;

`ifdef MIO_ARB_TIMEOUT_EN
    localparam int TB_TO = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TB_TO = 64;
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        dma_req = 1'b0, dma_lock = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic [31:0] bus_rdata = '0;
    logic [31:0] cpu_rdata, dma_rdata, bus_addr, bus_wdata;
    logic        cpu_ack, dma_ack, bus_mem_w, timeout_flag;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    mio_bus_arbiter #(.TIMEOUT_CYC(TB_TO)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_we(dma_we), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_mem_w(bus_mem_w), .bus_rdata(bus_rdata),
        .grant(grant), .timeout_flag(timeout_flag)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: 0 = nobody, 1 = CPU, 2 = DMA.
    int m_owner = 0;
    int m_last  = 2;
    int m_run   = 0;
    bit m_flag  = 1'b0;

    function automatic logic [133:0] dut_out();
        return {grant, cpu_ack, dma_ack, bus_mem_w, timeout_flag,
                bus_addr, bus_wdata, cpu_rdata, dma_rdata};
    endfunction

    function automatic logic [133:0] pack(input logic [1:0] g, input bit ca, input bit da,
                                          input bit mw, input bit tf);
        logic [31:0] a, w;
        a = ca ? cpu_addr  : (da ? dma_addr  : 32'd0);
        w = ca ? cpu_wdata : (da ? dma_wdata : 32'd0);
        return {g, ca, da, mw, tf, a, w, ca ? bus_rdata : 32'd0, da ? bus_rdata : 32'd0};
    endfunction

    function automatic logic [133:0] model_out();
        bit ca, da;
        logic [1:0] g;
        ca = (m_owner == 1) && cpu_req;
        da = (m_owner == 2) && dma_req;
        g  = (m_owner == 1) ? 2'b01 : ((m_owner == 2) ? 2'b10 : 2'b00);
        return pack(g, ca, da, (ca && cpu_we) || (da && dma_we), m_flag);
    endfunction

    task automatic model_step();
        bit keep, forced;
        int nxt;
        if (!rst) begin
            m_owner = 0; m_last = 2; m_run = 0; m_flag = 1'b0;
        end else begin
            keep   = (m_owner == 2) && dma_req && dma_lock;
            forced = keep && TO_EN && cpu_req && (m_run + 1 >= TB_TO);
            if (forced)                  nxt = 1;
            else if (keep)               nxt = 2;
            else if (cpu_req && dma_req) nxt = (m_last == 1) ? 2 : 1;
            else if (cpu_req)            nxt = 1;
            else if (dma_req)            nxt = 2;
            else                         nxt = 0;
            m_run  = (keep && nxt == 2) ? ((m_run + 1 > TB_TO) ? TB_TO : m_run + 1) : 0;
            m_flag = forced;
            if (nxt != 0) m_last = nxt;
            m_owner = nxt;
        end
    endtask

    task automatic cmp(input string name, input logic [133:0] act, input logic [133:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and check against the model.
    task automatic drive(input string tag, input bit r, input bit cr, input bit cw,
                         input bit dr, input bit dl, input bit dw,
                         input logic [31:0] ca, input logic [31:0] da);
        @(negedge clk);
        rst = r; cpu_req = cr; cpu_we = cw; dma_req = dr; dma_lock = dl; dma_we = dw;
        cpu_addr = ca; dma_addr = da;
        cpu_wdata = $urandom; dma_wdata = $urandom; bus_rdata = $urandom;
        #1;
        cmp(tag, dut_out(), model_out());
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
    endtask

    typedef struct packed {
        bit r, cr, cw, dr, dl, dw;
        logic [2:0] ofs;
        logic [1:0] g;
        bit ca, da, mw;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit cr, input bit cw, input bit dr,
                                input bit dl, input bit dw, input int ofs, input logic [1:0] g,
                                input bit ca, input bit da, input bit mw);
        vec_t v;
        v.r = r; v.cr = cr; v.cw = cw; v.dr = dr; v.dl = dl; v.dw = dw;
        v.ofs = ofs[2:0]; v.g = g; v.ca = ca; v.da = da; v.mw = mw;
        return v;
    endfunction

    vec_t tbl [30];

    initial begin
        //            r cr cw dr dl dw ofs grant  ca da mw
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        tbl[3]  = mk(1, 1, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0);
        tbl[4]  = mk(1, 1, 1, 0, 0, 0, 0, 2'b01, 1, 0, 1);
        tbl[5]  = mk(1, 0, 1, 0, 0, 0, 0, 2'b01, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        tbl[7]  = mk(1, 1, 1, 1, 0, 1, 0, 2'b00, 0, 0, 0);
        tbl[8]  = mk(1, 1, 1, 1, 0, 1, 0, 2'b01, 1, 0, 1);
        tbl[9]  = mk(1, 1, 1, 1, 0, 1, 0, 2'b10, 0, 1, 1);
        tbl[10] = mk(1, 1, 1, 1, 0, 1, 0, 2'b01, 1, 0, 1);
        tbl[11] = mk(1, 1, 1, 1, 0, 1, 0, 2'b10, 0, 1, 1);
        tbl[12] = mk(1, 1, 1, 1, 1, 1, 0, 2'b01, 1, 0, 1);
        for (int i = 0; i < 8; i++)
            tbl[13+i] = mk(1, 1, 0, 1, 1, 1, i, 2'b10, 0, 1, 1);
        tbl[21] = mk(1, 1, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0);
        tbl[22] = mk(1, 1, 0, 0, 0, 0, 0, 2'b01, 1, 0, 0);
        tbl[23] = mk(1, 0, 0, 1, 1, 1, 0, 2'b01, 0, 0, 0);
        tbl[24] = mk(1, 0, 0, 1, 1, 1, 0, 2'b10, 0, 1, 1);
        tbl[25] = mk(0, 0, 0, 1, 1, 1, 1, 2'b10, 0, 1, 1);
        tbl[26] = mk(0, 1, 0, 1, 1, 1, 2, 2'b00, 0, 0, 0);
        tbl[27] = mk(1, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0);
        tbl[28] = mk(1, 1, 0, 1, 0, 0, 0, 2'b01, 1, 0, 0);
        tbl[29] = mk(1, 1, 0, 1, 0, 0, 0, 2'b10, 0, 1, 0);

        for (int i = 0; i < 30; i++) begin
            drive($sformatf("model_tbl%0d", i), tbl[i].r, tbl[i].cr, tbl[i].cw,
                  tbl[i].dr, tbl[i].dl, tbl[i].dw,
                  32'hFFFF_FF00, 32'h000C_0000 + {29'd0, tbl[i].ofs});
`ifndef MIO_ARB_TIMEOUT_EN
            cmp($sformatf("tbl%0d", i), dut_out(),
                pack(tbl[i].g, tbl[i].ca, tbl[i].da, tbl[i].mw, 1'b0));
`endif
            advance();
        end

`ifdef MIO_ARB_TIMEOUT_EN
        // Forced release: DMA takes the bus alone, CPU then waits behind the lock.
        drive("to_rst", 0, 0, 0, 0, 0, 0, 32'h10, 32'h20);
        advance();
        drive("to_take", 1, 0, 0, 1, 1, 1, 32'h10, 32'h20);
        advance();
        for (int i = 0; i < 4; i++) begin
            drive($sformatf("to_dma%0d", i), 1, 1, 0, 1, 1, 1, 32'h10, 32'h20 + i);
            cmp($sformatf("to_dma_grant%0d", i), {132'd0, grant}, {132'd0, 2'b10});
            cmp($sformatf("to_dma_flag%0d", i), {133'd0, timeout_flag}, 134'd0);
            advance();
        end
        drive("to_cpu", 1, 1, 0, 1, 1, 1, 32'h10, 32'h30);
        cmp("to_cpu_grant", {132'd0, grant}, {132'd0, 2'b01});
        cmp("to_cpu_flag", {133'd0, timeout_flag}, 134'd1);
        advance();
        drive("to_after", 1, 1, 0, 1, 1, 1, 32'h10, 32'h30);
        cmp("to_after_flag", {133'd0, timeout_flag}, 134'd0);
        advance();
`endif

        for (int i = 0; i < 3000; i++) begin
            drive("rand", $urandom_range(63) != 0, $urandom_range(3) != 0, $urandom_range(1) != 0,
                  $urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(1) != 0,
                  $urandom, $urandom);
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mio_bus_arbiter.md
MIO_BUS_ARBITER -- requirements
Module: mio_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 64, max consecutive locked DMA cycles before forced release.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-low reset.
REQ-004 cpu_req  in  1  CPU requests a bus cycle.
REQ-005 cpu_addr  in  32  CPU byte address.
REQ-006 cpu_wdata  in  32  CPU write data.
REQ-007 cpu_we  in  1  CPU write strobe.
REQ-008 cpu_rdata  out  32  read data to CPU.
REQ-009 cpu_ack  out  1  CPU cycle performed this clock.
REQ-010 dma_req, dma_lock  in  1 each  DMA request; lock holds the grant across a burst.
REQ-011 dma_addr, dma_wdata  in  32 each; dma_we  in  1  DMA address, write data, write strobe.
REQ-012 dma_rdata  out  32; dma_ack  out  1  DMA read data and acknowledge.
REQ-013 bus_addr, bus_wdata  out  32 each; bus_mem_w  out  1  drive the MIO address decoder.
REQ-014 bus_rdata  in  32  decoder read-back data.
REQ-015 grant  out  2  one-hot owner: 2'b01 CPU, 2'b10 DMA, 2'b00 none.
REQ-016 timeout_flag  out  1  one-cycle pulse on forced DMA release.

Function
REQ-017 The owner register (NONE/CPU/DMA) SHALL update each clock; grant SHALL reflect the owner register.
REQ-018 bus_addr, bus_wdata and bus_mem_w SHALL be a combinational mux of the owner's signals, gated by its req; all three SHALL be 0 when owner is NONE or the owner's req is low.
REQ-019 x_ack SHALL equal (owner==x) & x_req in the same cycle; x_rdata SHALL equal bus_rdata when x_ack, else 0.
REQ-020 Latency: a request raised with owner NONE SHALL be acked on the next clock; an owner holding req alone SHALL be acked every cycle.
REQ-021 Next owner: DMA SHALL keep ownership while dma_req & dma_lock, unless timeout fires.
REQ-022 Otherwise, with both requesting, the next owner SHALL be the master not granted last; last-granted SHALL reset to DMA, so CPU wins the first contention.
REQ-023 Otherwise, with one requester, that master SHALL become owner; with none, owner SHALL become NONE.
REQ-024 An owner dropping req mid-ownership SHALL lose ack in that cycle and lose the grant at the next clock.
REQ-025 A write SHALL never be issued for a master whose ack is low.

Reset
REQ-026 While rst==0 at a clock edge: owner NONE, last-granted DMA, lock counter 0, timeout_flag 0.
REQ-027 All acks, bus strobes and rdata outputs SHALL be 0 after reset.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no further ack.

Configuration
REQ-029 Macro MIO_ARB_TIMEOUT_EN selects the watchdog.
REQ-030 With MIO_ARB_TIMEOUT_EN defined, the counter SHALL count consecutive cycles owned by DMA under dma_lock, saturating at TIMEOUT_CYC.
REQ-031 At TIMEOUT_CYC with cpu_req high, ownership SHALL pass to CPU next clock, timeout_flag SHALL pulse for that cycle, and the counter SHALL clear on any owner change.
REQ-032 Without MIO_ARB_TIMEOUT_EN, the lock SHALL be honoured indefinitely and timeout_flag SHALL be tied 0; the port SHALL remain present.

Structure
REQ-033 Owner encodings (GNT_NONE/GNT_CPU/GNT_DMA) and the TIMEOUT_CYC default SHALL live in shared package mio_arb_pkg.
REQ-034 The watchdog counter SHALL be the sub-module mio_arb_wdog, instantiated only under MIO_ARB_TIMEOUT_EN.

Verification
REQ-035 Reset, then cpu_req=1, cpu_addr=32'hFFFF_FF00, cpu_we=0 -> next clock grant=01, cpu_ack=1, cpu_rdata=bus_rdata.
REQ-036 cpu_req and dma_req both held, no lock -> grant sequence 01,10,01,10; each ack in its own cycle only.
REQ-037 DMA owns with dma_lock=1 and writes to 32'h000C_0000..000C_0007; CPU requests meanwhile -> DMA acked 8 cycles with no CPU ack; CPU granted the clock after lock drops.
REQ-038 With MIO_ARB_TIMEOUT_EN and TIMEOUT_CYC=4, DMA locked and cpu_req high -> CPU granted after 4 DMA cycles; timeout_flag=1 for exactly one cycle.
REQ-039 rst=0 asserted mid-DMA burst -> grant=00, all acks and bus_mem_w 0 at the next edge; CPU granted first when both request after release.
